qr_column_loader: RTL and testbench
===================================

# qr_column_loader

Downstream consumer of the input sample FIFO in the QR decomposition datapath. It pops scalar words from the FIFO, assembles them into one column vector of `VECTOR_LEN` elements, and presents the full column to the QR core over a valid/ready handshake. It also tracks column position within the matrix and flags the last column of each matrix.

## Interface
- `DATA_WIDTH`, 16, width of one matrix element
- `VECTOR_LEN`, 4, elements per column (≥2)
- `MATRIX_COLS`, 4, columns per matrix (≥1)
- `IDX_WIDTH`, `$clog2(VECTOR_LEN)`, element counter width
- `COL_WIDTH`, `$clog2(MATRIX_COLS)` (min 1), column counter width

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rdata` in `DATA_WIDTH`: FIFO head word. Valid in the same cycle `fifo_empty`=0 (asynchronous register-file read at `r_addr`).
- `fifo_rd` out 1: pop request to the FIFO.
- `col_valid` out 1: assembled column available.
- `col_ready` in 1: QR core accepts the column.
- `col_data` out `DATA_WIDTH*VECTOR_LEN`: column. Element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; element 0 is the first word popped.
- `col_idx` out `COL_WIDTH`: column index within the matrix of the presented column.
- `col_last` out 1: presented column is column `MATRIX_COLS-1`.
- `busy` out 1: partial or full column held.

## Operation
- Two-state FSM: FILL and HOLD. Reset state is FILL.
- **FILL**
  - `fifo_rd = ~fifo_empty & ~reset`. The module never pops an empty FIFO.
  - On a pop, `fifo_rdata` is written into slot `elem_cnt` and `elem_cnt` increments.
  - A pop when `elem_cnt == VECTOR_LEN-1` writes the last slot, clears `elem_cnt` to 0, and moves the FSM to HOLD.
  - With `fifo_empty`=1, all state holds. Stalls may occur between any two elements.
- **HOLD**
  - `col_valid`=1 and `fifo_rd`=0.
  - `col_data`, `col_idx` and `col_last` stay stable until the transfer.
  - A transfer occurs when `col_valid & col_ready`. On transfer, the FSM returns to FILL and `col_idx` increments. It wraps to 0 after `MATRIX_COLS-1`.
- `col_last = (col_idx == MATRIX_COLS-1)`, combinational from the registered `col_idx`.
- `busy` = (state==HOLD) | (`elem_cnt` != 0).
- `col_ready` is ignored in FILL; no transfer occurs there.
- Slots not yet refilled keep the previous column's values. They are never observed, because `col_valid`=0 in FILL.
- **Reset:** synchronous and takes priority over everything. It applies in any state, including mid-column and during HOLD. A partial or held column is discarded. Reset values:
  - state FILL
  - `elem_cnt`=0, `col_idx`=0
  - `col_data`=0, `col_valid`=0, `col_last`=0 (when `MATRIX_COLS`>1), `busy`=0
  - `fifo_rd`=0 while `reset` is high.

## Timing
- `fifo_rd` is combinational from state, `fifo_empty` and `reset`. The FIFO samples it at the same edge that captures the data into the slot.
- With a continuously non-empty FIFO, pops occur on cycles 0..`VECTOR_LEN-1`. `col_valid` rises in cycle `VECTOR_LEN`.
- With `col_ready` tied high, the HOLD cycle is the transfer cycle and the next pop is in cycle `VECTOR_LEN+1`. Sustained throughput is one column per `VECTOR_LEN+1` cycles.
- `col_valid` falls in the cycle after the transfer. It never drops without a transfer except on reset.
- Back-pressure: `col_ready`=0 keeps the module in HOLD indefinitely with no pops. The FIFO may fill; its full handling is upstream's concern.
- No combinational path from `col_ready` to `fifo_rd`.

## Test plan
- **Reset then idle:** hold `fifo_empty`=1 for 10 cycles after reset → `fifo_rd`=0, `col_valid`=0, `busy`=0, `col_idx`=0.
- **Streaming:** FIFO preloaded with 0x0001..0x0010, `col_ready`=1, defaults → 4 columns, e.g. col0 `col_data`=0x0004_0003_0002_0001.
  - `col_idx` goes 0,1,2,3; `col_last`=1 only on the 4th column.
  - `col_valid` is high every 5th cycle.
- **Empty gaps mid-column:** `fifo_empty` toggles every other cycle → pops only in non-empty cycles, column contents still in order, `busy`=1 throughout the partial fill.
- **Back-pressure:** `col_ready`=0 for 20 cycles with the FIFO non-empty → `fifo_rd`=0 and `col_data` stable. Raising `col_ready` gives a transfer in that cycle and pops resume the next cycle.
- **Reset mid-column:** assert `reset` after 2 of 4 pops → outputs at reset values. The next column starts at slot 0 and `col_idx` restarts at 0.
- **Index wrap:** 5 columns with `MATRIX_COLS`=4 → `col_idx` sequence 0,1,2,3,0; `col_last` pulses on the 4th column only.

Source files
------------

// File: rtl/qr_column_loader.sv
// Pops scalar words from the input sample FIFO, packs them into one column of
// VECTOR_LEN elements and hands the column to the QR core over valid/ready.
module qr_column_loader #(
  parameter int DATA_WIDTH  = 16,
  parameter int VECTOR_LEN  = 4,
  parameter int MATRIX_COLS = 4,
  parameter int IDX_WIDTH   = $clog2(VECTOR_LEN),
  parameter int COL_WIDTH   = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_WIDTH-1:0]            fifo_rdata,
  output logic                             fifo_rd,
  output logic                             col_valid,
  input  logic                             col_ready,
  output logic [DATA_WIDTH*VECTOR_LEN-1:0] col_data,
  output logic [COL_WIDTH-1:0]             col_idx,
  output logic                             col_last,
  output logic                             busy
);

  localparam logic [IDX_WIDTH-1:0] LAST_ELEM = IDX_WIDTH'(VECTOR_LEN - 1);
  localparam logic [COL_WIDTH-1:0] LAST_COL  = COL_WIDTH'(MATRIX_COLS - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   elem_cnt_q, elem_cnt_d;
  logic [COL_WIDTH-1:0]   col_idx_q, col_idx_d;
  logic [DATA_WIDTH-1:0]  slot_q [VECTOR_LEN];
  logic [DATA_WIDTH-1:0]  slot_d [VECTOR_LEN];
  logic                   pop;

  // Pop depends only on state, empty flag and reset: col_ready never reaches fifo_rd.
  assign pop = (state_q == FILL) & ~fifo_empty & ~reset;

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    col_idx_d  = col_idx_q;
    for (int i = 0; i < VECTOR_LEN; i++) begin
      slot_d[i] = slot_q[i];
    end
    case (state_q)
      FILL: begin
        if (pop) begin
          slot_d[elem_cnt_q] = fifo_rdata;
          if (elem_cnt_q == LAST_ELEM) begin
            elem_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            elem_cnt_d = elem_cnt_q + IDX_WIDTH'(1);
          end
        end
      end
      HOLD: begin
        if (col_ready) begin
          state_d   = FILL;
          col_idx_d = (col_idx_q == LAST_COL) ? '0 : col_idx_q + COL_WIDTH'(1);
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      elem_cnt_q <= '0;
      col_idx_q  <= '0;
      for (int i = 0; i < VECTOR_LEN; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      elem_cnt_q <= elem_cnt_d;
      col_idx_q  <= col_idx_d;
      for (int i = 0; i < VECTOR_LEN; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  // Element 0 (first word popped) sits in the least significant lane.
  for (genvar gi = 0; gi < VECTOR_LEN; gi++) begin : g_lane
    assign col_data[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q[gi];
  end

  assign fifo_rd   = pop;
  assign col_valid = (state_q == HOLD);
  assign col_idx   = col_idx_q;
  assign col_last  = (col_idx_q == LAST_COL);
  assign busy      = (state_q == HOLD) | (elem_cnt_q != '0);

endmodule

// File: tb/tb_qr_column_loader.sv
// Randomized bench for qr_column_loader: a queue-based FIFO and a behavioural
// column model predict every output cycle by cycle.
module tb_qr_column_loader;
  localparam int DW = 16;
  localparam int VL = 4;
  localparam int MC = 4;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              fifo_empty = 1'b1;
  logic [DW-1:0]     fifo_rdata = '0;
  logic              fifo_rd;
  logic              col_valid;
  logic              col_ready = 1'b0;
  logic [DW*VL-1:0]  col_data;
  logic [CW-1:0]     col_idx;
  logic              col_last;
  logic              busy;

  qr_column_loader #(
    .DATA_WIDTH (DW),
    .VECTOR_LEN (VL),
    .MATRIX_COLS(MC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rd   (fifo_rd),
    .col_valid (col_valid),
    .col_ready (col_ready),
    .col_data  (col_data),
    .col_idx   (col_idx),
    .col_last  (col_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: words popped so far for the current column,
  // whether a full column is being presented, and the matrix column number.
  logic [DW-1:0]    fifo_q[$];
  logic [DW-1:0]    m_col[$];
  bit               m_hold = 1'b0;
  int               m_idx = 0;
  logic [DW*VL-1:0] m_data = '0;
  bit               gap = 1'b0;
  int               n_xfer = 0;
  int               n_last = 0;
  logic [DW*VL-1:0] last_xfer_data = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
  endtask

  // One clock cycle: drive FIFO view, compare outputs mid-cycle, advance model at the edge.
  task automatic step();
    bit exp_rd;
    fifo_empty = gap || (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? DW'($urandom) : fifo_q[0];
    @(negedge clk);
    exp_rd = !m_hold && !fifo_empty && !reset;
    check("fifo_rd",   64'(fifo_rd),   64'(exp_rd));
    check("col_valid", 64'(col_valid), 64'(m_hold));
    check("busy",      64'(busy),      64'(m_hold || (m_col.size() != 0)));
    check("col_idx",   64'(col_idx),   64'(m_idx));
    check("col_last",  64'(col_last),  64'(m_idx == MC - 1));
    if (m_hold) check("col_data", 64'(col_data), 64'(m_data));
    @(posedge clk);
    if (reset) begin
      m_hold = 1'b0;
      m_col.delete();
      m_idx = 0;
    end else if (m_hold) begin
      if (col_ready) begin
        $display("xfer col_idx=%0d last=%0d data=%h", m_idx, (m_idx == MC - 1), m_data);
        last_xfer_data = m_data;
        if (m_idx == MC - 1) n_last++;
        m_hold = 1'b0;
        m_idx  = (m_idx + 1) % MC;
        n_xfer++;
      end
    end else if (exp_rd) begin
      m_col.push_back(fifo_q.pop_front());
      if (m_col.size() == VL) begin
        for (int i = 0; i < VL; i++) m_data[i*DW +: DW] = m_col[i];
        m_hold = 1'b1;
        m_col.delete();
      end
    end
    #1;
  endtask

  initial begin
    int x0;
    int l0;
    // Power-up reset: outputs are unknown until the first edge, so no checks here.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset then idle.
    repeat (10) step();
    check("idle_col_data", 64'(col_data), 64'h0);

    // Streaming 0x0001..0x0010 with col_ready high: 4 columns, one per 5 cycles.
    col_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(DW'(i));
    x0 = n_xfer;
    l0 = n_last;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 4) check("stream_col0", 64'(last_xfer_data), 64'h0004_0003_0002_0001);
    end
    check("stream_xfers", 64'(n_xfer - x0), 64'd4);
    check("stream_lasts", 64'(n_last - l0), 64'd1);
    check("stream_col3",  64'(last_xfer_data), 64'h0010_000f_000e_000d);

    // Empty gaps every other cycle.
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    for (int c = 0; c < 30; c++) begin
      gap = (c % 2) == 0;
      step();
    end
    gap = 1'b0;

    // Back-pressure with a non-empty FIFO, then release.
    col_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    repeat (25) step();
    col_ready = 1'b1;
    repeat (10) step();

    // Drain, then reset after two pops of a new column.
    for (int c = 0; c < 50 && (fifo_q.size() != 0 || m_hold || m_col.size() != 0); c++) step();
    check("drained", 64'(fifo_q.size() + m_col.size()), 64'd0);
    for (int i = 0; i < 8; i++) push(DW'($urandom));
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_col_data", 64'(col_data), 64'h0);
    check("rst_col_idx",  64'(col_idx),  64'h0);
    check("rst_busy",     64'(busy),     64'h0);
    repeat (12) step();

    // Index wrap: 5 more columns from index 0.
    for (int c = 0; c < 50 && (fifo_q.size() != 0 || m_hold || m_col.size() != 0); c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) push(DW'($urandom));
    l0 = n_last;
    repeat (25) step();
    check("wrap_lasts", 64'(n_last - l0), 64'd1);
    check("wrap_idx",   64'(col_idx),     64'd1);

    // Random traffic with gaps, back-pressure and occasional reset.
    for (int c = 0; c < 400; c++) begin
      gap       = ($urandom_range(0, 2) == 0);
      col_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      if (fifo_q.size() < 6 && $urandom_range(0, 1) == 1) push(DW'($urandom));
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
